// File: rtl/mux_scan_sel.sv
// ---------------------------------------------------------------------------
// mux_scan_sel
//   Parametrised N-channel, W-bit registered multiplexer with an auto-scan
//   mode. In MANUAL mode the selected channel follows sel. In SCAN mode the
//   block steps through every channel and stays DWELL enabled cycles on each.
//   It sits between switch/sensor inputs and the LEDR/HEX display logic.
//
// Parameters
//   WIDTH     bit width of each data channel (>=1)
//   CHANNELS  number of input channels (>=2)
//   DWELL     cycles spent on each channel in scan mode (>=1)
//   SEL_W     $clog2(CHANNELS), derived and not overridable
//
// Ports
//   clk      single clock, all state updates on the rising edge
//   reset    asynchronous, active-high reset
//   data_in  packed channels, channel c = data_in[c*WIDTH +: WIDTH]
//   sel      manual-mode channel select
//   mode     0 = MANUAL, 1 = SCAN
//   enable   1 = advance/sample, 0 = freeze all state
//   out      registered selected data
//   cur_ch   channel that out was taken from
//   out_vld  1 = out was sampled on the last edge
//   wrap     one-cycle pulse when the scan steps from CHANNELS-1 to 0
// ---------------------------------------------------------------------------
module mux_scan_sel #(
  parameter  int WIDTH    = 1,
  parameter  int CHANNELS = 4,
  parameter  int DWELL    = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      enable,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          cur_ch,
  output logic                      out_vld,
  output logic                      wrap
);

  localparam int                CNT_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0]  LAST_CH    = SEL_W'(CHANNELS - 1);

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_e;

  state_e           state_q,  state_d;
  logic [SEL_W-1:0] cur_ch_q, cur_ch_d;
  logic [CNT_W-1:0] dwell_q,  dwell_d;
  logic [WIDTH-1:0] out_q,    out_d;
  logic             vld_q,    vld_d;
  logic             wrap_q,   wrap_d;

  logic [SEL_W-1:0] sel_clamped;
  logic [31:0]      sel_ext;
  logic [SEL_W-1:0] next_ch;

  // Out-of-range selects (only possible for non-power-of-2 CHANNELS) map to
  // the last channel. The compare is done at 32 bits so it stays a real
  // comparison even when every sel code is legal.
  always_comb begin
    sel_ext     = 32'(sel);
    sel_clamped = sel;
    if (sel_ext >= 32'(CHANNELS)) begin
      sel_clamped = LAST_CH;
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    dwell_d  = dwell_q;
    out_d    = out_q;
    vld_d    = 1'b0;
    wrap_d   = 1'b0;
    next_ch  = cur_ch_q;

    if (enable) begin
      state_d = mode ? ST_SCAN : ST_MANUAL;

      if (state_d == ST_MANUAL) begin
        next_ch = sel_clamped;
        dwell_d = '0;
      end else if (state_q != ST_SCAN) begin
        // Entering SCAN: the entry edge is the first cycle of a full dwell
        // on whatever channel is already current.
        next_ch = cur_ch_q;
        dwell_d = '0;
      end else if (dwell_q < DWELL_LAST) begin
        next_ch = cur_ch_q;
        dwell_d = dwell_q + CNT_W'(1);
      end else begin
        dwell_d = '0;
        if (cur_ch_q == LAST_CH) begin
          next_ch = '0;
          wrap_d  = 1'b1;
        end else begin
          next_ch = cur_ch_q + SEL_W'(1);
        end
      end

      // out and cur_ch are loaded from the same next_ch so they always agree.
      cur_ch_d = next_ch;
      out_d    = data_in[int'(next_ch)*WIDTH +: WIDTH];
      vld_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_MANUAL;
      cur_ch_q <= '0;
      dwell_q  <= '0;
      out_q    <= '0;
      vld_q    <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
      dwell_q  <= dwell_d;
      out_q    <= out_d;
      vld_q    <= vld_d;
      wrap_q   <= wrap_d;
    end
  end

  assign out     = out_q;
  assign cur_ch  = cur_ch_q;
  assign out_vld = vld_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_mux_scan_sel.sv
// ---------------------------------------------------------------------------
// tb_mux_scan_sel
//   Scoreboard bench for mux_scan_sel. Two instances:
//     dut_a : WIDTH=8, CHANNELS=4, DWELL=3
//     dut_b : WIDTH=4, CHANNELS=5, DWELL=1 (non-power-of-2, advance every edge)
//   Stimulus pushes hand-computed expected {out, cur_ch, wrap} per enabled
//   edge; per-instance monitors pop and compare whenever out_vld is high.
// ---------------------------------------------------------------------------
module tb_mux_scan_sel;

  logic clk;
  logic reset;

  logic [31:0] data_a;
  logic [1:0]  sel_a;
  logic        mode_a, en_a;
  logic [7:0]  out_a;
  logic [1:0]  ch_a;
  logic        vld_a, wrap_a;

  logic [19:0] data_b;
  logic [2:0]  sel_b;
  logic        mode_b, en_b;
  logic [3:0]  out_b;
  logic [2:0]  ch_b;
  logic        vld_b, wrap_b;

  typedef struct {
    logic [7:0] out;
    logic [2:0] ch;
    logic       wrap;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  mux_scan_sel #(.WIDTH(8), .CHANNELS(4), .DWELL(3)) dut_a (
    .clk(clk), .reset(reset), .data_in(data_a), .sel(sel_a), .mode(mode_a),
    .enable(en_a), .out(out_a), .cur_ch(ch_a), .out_vld(vld_a), .wrap(wrap_a)
  );

  mux_scan_sel #(.WIDTH(4), .CHANNELS(5), .DWELL(1)) dut_b (
    .clk(clk), .reset(reset), .data_in(data_b), .sel(sel_b), .mode(mode_b),
    .enable(en_b), .out(out_b), .cur_ch(ch_b), .out_vld(vld_b), .wrap(wrap_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitors sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (vld_a) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_vld", 32'(vld_a), 32'd0);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        check("a_out",    32'(out_a),  32'(e.out));
        check("a_cur_ch", 32'(ch_a),   32'(e.ch));
        check("a_wrap",   32'(wrap_a), 32'(e.wrap));
      end
    end
  end

  always @(negedge clk) begin
    if (vld_b) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_vld", 32'(vld_b), 32'd0);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        check("b_out",    32'(out_b),  32'(e.out));
        check("b_cur_ch", 32'(ch_b),   32'(e.ch));
        check("b_wrap",   32'(wrap_b), 32'(e.wrap));
      end
    end
  end

  // One enabled edge on dut_a with its expected response.
  task automatic sa(input logic m, input logic [1:0] s,
                    input logic [7:0] o, input logic [2:0] c, input logic w);
    exp_t e;
    e.out = o; e.ch = c; e.wrap = w;
    q_a.push_back(e);
    mode_a = m; sel_a = s; en_a = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic sb(input logic m, input logic [2:0] s,
                    input logic [7:0] o, input logic [2:0] c, input logic w);
    exp_t e;
    e.out = o; e.ch = c; e.wrap = w;
    q_b.push_back(e);
    mode_b = m; sel_b = s; en_b = 1'b1;
    @(posedge clk); #1;
  endtask

  // Asserts reset between edges and checks that outputs clear immediately.
  task automatic pulse_reset();
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check("rst_async_out",  32'(out_a),  32'd0);
    check("rst_async_ch",   32'(ch_a),   32'd0);
    check("rst_async_vld",  32'(vld_a),  32'd0);
    check("rst_async_wrap", 32'(wrap_a), 32'd0);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    data_a = {8'h44, 8'h33, 8'h22, 8'h11};
    data_b = {4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
    sel_a = '0; mode_a = 1'b0; en_a = 1'b0;
    sel_b = '0; mode_b = 1'b0; en_b = 1'b0;
    #12;
    check("reset_out_a",  32'(out_a),  32'd0);
    check("reset_ch_a",   32'(ch_a),   32'd0);
    check("reset_vld_a",  32'(vld_a),  32'd0);
    check("reset_wrap_a", 32'(wrap_a), 32'd0);
    check("reset_out_b",  32'(out_b),  32'd0);
    check("reset_vld_b",  32'(vld_b),  32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Manual selection follows sel with one cycle latency.
    sa(1'b0, 2'd0, 8'h11, 3'd0, 1'b0);
    sa(1'b0, 2'd1, 8'h22, 3'd1, 1'b0);
    sa(1'b0, 2'd2, 8'h33, 3'd2, 1'b0);
    sa(1'b0, 2'd3, 8'h44, 3'd3, 1'b0);

    // Scan from reset, DWELL=3, sel ignored; wrap on the 44->11 edge.
    pulse_reset();
    sa(1'b1, 2'd3, 8'h11, 3'd0, 1'b0);
    sa(1'b1, 2'd3, 8'h11, 3'd0, 1'b0);
    sa(1'b1, 2'd3, 8'h11, 3'd0, 1'b0);
    sa(1'b1, 2'd3, 8'h22, 3'd1, 1'b0);
    sa(1'b1, 2'd3, 8'h22, 3'd1, 1'b0);
    sa(1'b1, 2'd3, 8'h22, 3'd1, 1'b0);
    sa(1'b1, 2'd0, 8'h33, 3'd2, 1'b0);
    sa(1'b1, 2'd0, 8'h33, 3'd2, 1'b0);
    sa(1'b1, 2'd0, 8'h33, 3'd2, 1'b0);
    sa(1'b1, 2'd0, 8'h44, 3'd3, 1'b0);
    sa(1'b1, 2'd0, 8'h44, 3'd3, 1'b0);
    sa(1'b1, 2'd0, 8'h44, 3'd3, 1'b0);
    sa(1'b1, 2'd1, 8'h11, 3'd0, 1'b1);
    sa(1'b1, 2'd1, 8'h11, 3'd0, 1'b0);
    sa(1'b1, 2'd1, 8'h11, 3'd0, 1'b0);
    sa(1'b1, 2'd1, 8'h22, 3'd1, 1'b0);
    sa(1'b1, 2'd1, 8'h22, 3'd1, 1'b0);
    sa(1'b1, 2'd1, 8'h22, 3'd1, 1'b0);
    sa(1'b1, 2'd1, 8'h33, 3'd2, 1'b0);
    sa(1'b1, 2'd1, 8'h33, 3'd2, 1'b0);

    // Freeze mid-dwell on ch2 for 5 cycles; mode change must not be taken.
    mode_a = 1'b0; sel_a = 2'd0; en_a = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("freeze_out",  32'(out_a),  32'h33);
      check("freeze_ch",   32'(ch_a),   32'd2);
      check("freeze_vld",  32'(vld_a),  32'd0);
      check("freeze_wrap", 32'(wrap_a), 32'd0);
    end
    // Dwell resumes at the held count: one more cycle on ch2, then ch3.
    sa(1'b1, 2'd0, 8'h33, 3'd2, 1'b0);
    sa(1'b1, 2'd0, 8'h44, 3'd3, 1'b0);
    sa(1'b1, 2'd0, 8'h44, 3'd3, 1'b0);

    // Back to manual with sel=1, then scan again from ch1 with a full dwell.
    sa(1'b0, 2'd1, 8'h22, 3'd1, 1'b0);
    sa(1'b1, 2'd3, 8'h22, 3'd1, 1'b0);
    sa(1'b1, 2'd3, 8'h22, 3'd1, 1'b0);
    sa(1'b1, 2'd3, 8'h22, 3'd1, 1'b0);
    sa(1'b1, 2'd3, 8'h33, 3'd2, 1'b0);
    sa(1'b1, 2'd3, 8'h33, 3'd2, 1'b0);

    // Reset mid-scan; with mode=1 the scan restarts at ch0.
    pulse_reset();
    sa(1'b1, 2'd2, 8'h11, 3'd0, 1'b0);
    sa(1'b1, 2'd2, 8'h11, 3'd0, 1'b0);
    sa(1'b1, 2'd2, 8'h11, 3'd0, 1'b0);
    sa(1'b1, 2'd2, 8'h22, 3'd1, 1'b0);
    en_a = 1'b0;

    // Five channels: out-of-range sel clamps to ch4; DWELL=1 scan.
    sb(1'b0, 3'd7, 8'h5, 3'd4, 1'b0);
    sb(1'b0, 3'd5, 8'h5, 3'd4, 1'b0);
    sb(1'b0, 3'd2, 8'h3, 3'd2, 1'b0);
    sb(1'b0, 3'd0, 8'h1, 3'd0, 1'b0);
    sb(1'b1, 3'd6, 8'h1, 3'd0, 1'b0);
    sb(1'b1, 3'd6, 8'h2, 3'd1, 1'b0);
    sb(1'b1, 3'd6, 8'h3, 3'd2, 1'b0);
    sb(1'b1, 3'd6, 8'h4, 3'd3, 1'b0);
    sb(1'b1, 3'd6, 8'h5, 3'd4, 1'b0);
    sb(1'b1, 3'd6, 8'h1, 3'd0, 1'b1);
    sb(1'b1, 3'd6, 8'h2, 3'd1, 1'b0);
    sb(1'b0, 3'd3, 8'h4, 3'd3, 1'b0);
    en_b = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("a_queue_drained", 32'(q_a.size()), 32'd0);
    check("b_queue_drained", 32'(q_b.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
